// File: rtl/softermax_run_sum_if.sv
// Beat/result handshake bundle for softermax_run_sum: input beats (vector + max + last)
// and the per-sequence (max, sum) result.
interface softermax_run_sum_if #(
    parameter int BW       = 8,
    parameter int VEC_SIZE = 5,
    parameter int SUM_W    = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic signed [BW-1:0] in_vec [VEC_SIZE-1:0];
    logic signed [BW-1:0] in_max;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [BW-1:0] out_max;
    logic [SUM_W-1:0]     out_sum;

    modport master (
        output in_valid, in_last, in_vec, in_max, out_ready,
        input  in_ready, out_valid, out_max, out_sum
    );

    modport slave (
        input  in_valid, in_last, in_vec, in_max, out_ready,
        output in_ready, out_valid, out_max, out_sum
    );
endinterface

// File: rtl/softermax_run_sum.sv
// Softermax running denominator: sum of 2^(x - m) with an integer-valued running max.
// Define SOFTERMAX_RUN_SUM_ROUND_EN for round-half-up right shifts (default truncates).
module softermax_run_sum #(
    parameter int BW       = 8,
    parameter int FW       = 2,
    parameter int VEC_SIZE = 5,
    parameter int SUM_W    = 16,
    parameter int SUM_FW   = 8
) (
    input logic                clk,
    input logic                rst,
    softermax_run_sum_if.slave bus
);
    localparam int LW  = SUM_W + $clog2(VEC_SIZE);
    localparam int SHW = BW + 1 - FW;
    localparam logic [SHW-1:0] SH_LIM = SHW'(SUM_W);
    // 2^(-k/4) in Q16; rescaled to SUM_FW with rounding (LUT assumes FW = 2)
    localparam logic [31:0] LUT_Q16 [4] = '{32'd65536, 32'd55109, 32'd46341, 32'd38968};

    function automatic logic [SUM_W-1:0] lut(input logic [FW-1:0] ef);
        logic [31:0] q;
        q = (LUT_Q16[ef] + (32'd1 << (15 - SUM_FW))) >> (16 - SUM_FW);
        return SUM_W'(q);
    endfunction

    function automatic logic [LW-1:0] shr(input logic [LW-1:0] v, input logic [SHW-1:0] sh);
`ifdef SOFTERMAX_RUN_SUM_ROUND_EN
        logic [LW:0] t;
        if (sh >= SH_LIM) return '0;
        if (sh == '0) return v;
        t = {1'b0, v} + ((LW+1)'(1) << (sh - 1'b1));
        return LW'(t >> sh);
`else
        if (sh >= SH_LIM) return '0;
        return v >> sh;
`endif
    endfunction

    logic                 advance;
    logic                 s1_valid;
    logic [LW-1:0]        s1_sum;
    logic signed [BW-1:0] s1_max;
    logic                 s1_last;
    logic signed [BW-1:0] run_max;
    logic [SUM_W-1:0]     run_sum;
    logic                 first;
    logic                 out_valid_r;
    logic signed [BW-1:0] out_max_r;
    logic [SUM_W-1:0]     out_sum_r;

    logic [LW-1:0]        beat_sum;
    logic signed [BW:0]   d;
    logic [BW:0]          e;

    logic signed [BW-1:0] new_max;
    logic [BW:0]          dr;
    logic [BW:0]          db;
    logic [SHW-1:0]       s_r;
    logic [SHW-1:0]       s_b;
    logic [LW:0]          total;
    logic signed [BW-1:0] merged_max;
    logic [SUM_W-1:0]     merged_sum;

    assign advance       = !(out_valid_r && !bus.out_ready);
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_r;
    assign bus.out_max   = out_max_r;
    assign bus.out_sum   = out_sum_r;

    always_comb begin
        beat_sum = '0;
        d        = '0;
        e        = '0;
        for (int i = 0; i < VEC_SIZE; i++) begin
            d = {bus.in_vec[i][BW-1], bus.in_vec[i]} - {bus.in_max[BW-1], bus.in_max};
            // elements above the supplied max are clipped to contribute 1.0
            if (!d[BW] && (d != '0)) d = '0;
            e = -d;
            beat_sum = beat_sum + shr(LW'(lut(e[FW-1:0])), SHW'(e >> FW));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_max   <= '0;
            s1_last  <= 1'b0;
        end else if (advance) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sum  <= beat_sum;
                s1_max  <= bus.in_max;
                s1_last <= bus.in_last;
            end
        end
    end

    always_comb begin
        new_max    = (s1_max > run_max) ? s1_max : run_max;
        dr         = {new_max[BW-1], new_max} - {run_max[BW-1], run_max};
        db         = {new_max[BW-1], new_max} - {s1_max[BW-1], s1_max};
        s_r        = SHW'(dr >> FW);
        s_b        = SHW'(db >> FW);
        total      = '0;
        merged_max = s1_max;
        if (first) begin
            total = {1'b0, s1_sum};
        end else begin
            total      = {1'b0, shr(LW'(run_sum), s_r)} + {1'b0, shr(s1_sum, s_b)};
            merged_max = new_max;
        end
        merged_sum = (|total[LW:SUM_W]) ? '1 : total[SUM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_max     <= '0;
            run_sum     <= '0;
            first       <= 1'b1;
            out_valid_r <= 1'b0;
            out_max_r   <= '0;
            out_sum_r   <= '0;
        end else if (advance) begin
            if (s1_valid) begin
                run_max <= merged_max;
                run_sum <= merged_sum;
                first   <= s1_last;
            end
            out_valid_r <= s1_valid && s1_last;
            if (s1_valid && s1_last) begin
                out_max_r <= merged_max;
                out_sum_r <= merged_sum;
            end
        end
    end
endmodule

// File: tb/tb_softermax_run_sum.sv
// Scoreboard bench for softermax_run_sum: directed beats push expected (max, sum),
// a monitor pops and compares on each output handshake.
module tb_softermax_run_sum;
    localparam int BW       = 8;
    localparam int VEC_SIZE = 5;
    localparam int SUM_W    = 16;

    typedef logic signed [BW-1:0] vec_t [VEC_SIZE];
    typedef struct {
        int max;
        int sum;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    softermax_run_sum_if #(.BW(BW), .VEC_SIZE(VEC_SIZE), .SUM_W(SUM_W)) bus ();

    softermax_run_sum #(
        .BW(BW), .FW(2), .VEC_SIZE(VEC_SIZE), .SUM_W(SUM_W), .SUM_FW(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef SOFTERMAX_RUN_SUM_ROUND_EN
    localparam int RESCALED = 1388;
`else
    localparam int RESCALED = 1387;
`endif

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d, input int e);
        vec_t v;
        v[0] = BW'(a);
        v[1] = BW'(b);
        v[2] = BW'(c);
        v[3] = BW'(d);
        v[4] = BW'(e);
        return v;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send(input vec_t v, input int mx, input bit last, input int exp_max,
                        input int exp_sum);
        int   n = 0;
        exp_t x;
        for (int i = 0; i < VEC_SIZE; i++) bus.in_vec[i] = v[i];
        bus.in_max   = BW'(mx);
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        if (last) begin
            x.max = exp_max;
            x.sum = exp_sum;
            exp_q.push_back(x);
        end
        forever begin
            #1;
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=no_accept required=accept");
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual_sum=%0d required=none", bus.out_sum);
                end else begin
                    x = exp_q.pop_front();
                    check("out_max", $signed(bus.out_max), x.max);
                    check("out_sum", bus.out_sum, x.sum);
                end
            end
        end
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_max    = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < VEC_SIZE; i++) bus.in_vec[i] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_max", $signed(bus.out_max), 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // single last beat, latency of two cycles
        send(mk(8, 8, 8, 8, 8), 8, 1, 8, 1280);
        check("lat_cycle1_valid", bus.out_valid, 0);
        @(negedge clk);
        check("lat_cycle2_valid", bus.out_valid, 1);

        // back-to-back stream
        send(mk(8, 4, 0, 7, 6), 8, 1, 8, 844);
        send(mk(0, 0, 0, 0, 0), 0, 0, 0, 0);
        send(mk(4, 4, 4, 4, 4), 4, 1, 4, 1920);
        send(mk(4, 4, 4, 4, 4), 4, 0, 0, 0);
        send(mk(0, 0, 0, 0, 0), 0, 1, 4, 1920);
        send(mk(7, -32, -32, -32, -32), 8, 1, 8, 215);
        send(mk(7, -32, -32, -32, -32), 8, 0, 0, 0);
        send(mk(12, 12, 12, 12, 12), 12, 1, 12, RESCALED);
        send(mk(12, 0, 0, 0, 0), 8, 1, 8, 512);
        repeat (3) @(negedge clk);

        // backpressure: result held, queued beat not consumed
        bus.out_ready = 1'b0;
        send(mk(8, 8, 8, 8, 8), 8, 1, 8, 1280);
        @(negedge clk);
        fork
            send(mk(0, -4, 0, 0, 0), 0, 1, 0, 1152);
            begin
                repeat (5) begin
                    #1;
                    check("stall_out_valid", bus.out_valid, 1);
                    check("stall_out_max", $signed(bus.out_max), 8);
                    check("stall_out_sum", bus.out_sum, 1280);
                    check("stall_in_ready", bus.in_ready, 0);
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        check("bp_cycle1_valid", bus.out_valid, 0);
        @(negedge clk);
        check("bp_cycle2_valid", bus.out_valid, 1);

        // reset mid-sequence discards the partial beat
        send(mk(8, 8, 8, 8, 8), 8, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(mk(0, 0, 0, 0, 0), 0, 1, 0, 1280);

        // saturation over a long sequence
        for (int i = 0; i < 60; i++) send(mk(8, 8, 8, 8, 8), 8, (i == 59), 8, 65535);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual_pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
